oven_zone_thermal: RTL and testbench

//   Clocked, multi-zone oven temperature model with per-zone preheat detection.

---
 rtl/oven_pkg.sv | 19 +
 rtl/oven_zone.sv | 178 +++++++++++++++++
 rtl/oven_zone_thermal.sv | 85 ++++++++
 tb/tb_oven_zone_thermal.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oven_pkg.sv
// Shared types and default constants for the oven zone thermal model.
package oven_pkg;

  localparam int unsigned TempWDefault   = 10;
  localparam int unsigned AmbientDefault = 65;
  localparam int unsigned TempMaxDefault = 511;

  typedef logic [TempWDefault-1:0] temp_t;
  typedef logic [1:0]              heat_t;

  typedef enum logic [2:0] {
    StIdle,
    StHeating,
    StSettling,
    StReady,
    StCooling
  } zone_state_t;

endpackage

// File: rtl/oven_zone.sv
// One oven zone: temperature integrator, tolerance-band compare, settle dwell and preheat FSM.
// Over-temperature trip logic is present only when OVERTEMP_TRIP_EN is defined.
module oven_zone
  import oven_pkg::*;
#(
  parameter int unsigned TEMP_W       = TempWDefault,
  parameter int unsigned AMBIENT      = AmbientDefault,
  parameter int unsigned TEMP_MAX     = TempMaxDefault,
  parameter int unsigned TOL          = 2,
  parameter int unsigned SETTLE_TICKS = 4,
  parameter int unsigned COOL_RATE    = 1
`ifdef OVERTEMP_TRIP_EN
  ,
  parameter int unsigned TRIP_LIMIT   = 480
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              enable_i,
  input  logic [TEMP_W-1:0] target_i,
  input  heat_t             heat_i,
  output logic [TEMP_W-1:0] temp_o,
  output logic              preheated_o,
  output logic              fault_o
);

  // Two guard bits keep target+TOL and temp+heat free of overflow.
  localparam int unsigned XW     = TEMP_W + 2;
  localparam int unsigned DwellW = $clog2(SETTLE_TICKS + 1);

  localparam logic [XW-1:0]     AmbX    = XW'(AMBIENT);
  localparam logic [XW-1:0]     MaxX    = XW'(TEMP_MAX);
  localparam logic [XW-1:0]     TolX    = XW'(TOL);
  localparam logic [XW-1:0]     CoolX   = XW'(COOL_RATE);
  localparam logic [XW-1:0]     FloorX  = XW'(AMBIENT + COOL_RATE);
  localparam logic [DwellW:0]   SettleX = (DwellW + 1)'(SETTLE_TICKS);

  zone_state_t       state_q, state_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [DwellW:0]   dwell_inc;
  logic              pre_q, pre_d;

  logic [XW-1:0] temp_x, tgt_x, sum_x, next_x, lo_x, hi_x;
  logic          heat_on, force_cool, in_band;

`ifdef OVERTEMP_TRIP_EN
  localparam logic [XW-1:0] TripX  = XW'(TRIP_LIMIT);
  localparam logic [XW-1:0] ClearX = XW'(AMBIENT + TOL);

  logic fault_q, fault_d, trip;

  assign heat_on    = enable_i && (heat_i != 2'b00) && !fault_q;
  assign trip       = !fault_q && (next_x >= TripX);
  assign force_cool = !enable_i || fault_q || trip;
  assign fault_o    = fault_q;

  // Fault is sticky until the oven is switched off and the zone is back near ambient.
  always_comb begin
    fault_d = fault_q;
    if (tick_i) begin
      if (trip) begin
        fault_d = 1'b1;
      end else if (fault_q && !enable_i && (next_x <= ClearX)) begin
        fault_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign heat_on    = enable_i && (heat_i != 2'b00);
  assign force_cool = !enable_i;
  assign fault_o    = 1'b0;
`endif

  always_comb begin
    temp_x = XW'(temp_q);
    tgt_x  = XW'(target_i);
    sum_x  = temp_x + XW'(heat_i);
    if (heat_on) begin
      next_x = (sum_x > MaxX) ? MaxX : sum_x;
    end else begin
      next_x = (temp_x <= FloorX) ? AmbX : temp_x - CoolX;
    end
    lo_x    = (tgt_x > TolX) ? tgt_x - TolX : '0;
    hi_x    = ((tgt_x + TolX) > MaxX) ? MaxX : tgt_x + TolX;
    // A target beyond the ceiling is unreachable even if the clipped band touches it.
    in_band = (tgt_x <= MaxX) && (next_x >= lo_x) && (next_x <= hi_x);
  end

  always_comb begin
    state_d   = state_q;
    temp_d    = temp_q;
    dwell_d   = dwell_q;
    pre_d     = pre_q;
    dwell_inc = {1'b0, dwell_q} + (DwellW + 1)'(1);
    if (tick_i) begin
      temp_d = next_x[TEMP_W-1:0];
      if (force_cool) begin
        pre_d   = 1'b0;
        dwell_d = '0;
        if ((state_q == StIdle || state_q == StCooling) && !enable_i && (next_x == AmbX)) begin
          state_d = StIdle;
        end else begin
          state_d = StCooling;
        end
      end else begin
        unique case (state_q)
          StIdle, StCooling: begin
            state_d = StHeating;
            dwell_d = '0;
          end
          StHeating: begin
            if (in_band) begin
              dwell_d = DwellW'(1);
              if (SETTLE_TICKS <= 1) begin
                state_d = StReady;
                pre_d   = 1'b1;
              end else begin
                state_d = StSettling;
              end
            end
          end
          StSettling: begin
            if (in_band) begin
              dwell_d = dwell_inc[DwellW-1:0];
              if (dwell_inc >= SettleX) begin
                state_d = StReady;
                pre_d   = 1'b1;
              end
            end else begin
              state_d = StHeating;
              dwell_d = '0;
            end
          end
          StReady: begin
            if (!in_band) begin
              state_d = StHeating;
              pre_d   = 1'b0;
              dwell_d = '0;
            end
          end
          default: begin
            state_d = StIdle;
            pre_d   = 1'b0;
            dwell_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      temp_q  <= TEMP_W'(AMBIENT);
      dwell_q <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      dwell_q <= dwell_d;
      pre_q   <= pre_d;
    end
  end

  assign temp_o      = temp_q;
  assign preheated_o = pre_q;

endmodule

// File: rtl/oven_zone_thermal.sv
// Multi-zone oven thermal model: tick prescaler, per-zone instances and all-preheated flag.
// Optional over-temperature trip is enabled by defining OVERTEMP_TRIP_EN.
module oven_zone_thermal
  import oven_pkg::*;
#(
  parameter int unsigned ZONES        = 2,
  parameter int unsigned TEMP_W       = TempWDefault,
  parameter int unsigned AMBIENT      = AmbientDefault,
  parameter int unsigned TEMP_MAX     = TempMaxDefault,
  parameter int unsigned TOL          = 2,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned SETTLE_TICKS = 4,
  parameter int unsigned COOL_RATE    = 1
`ifdef OVERTEMP_TRIP_EN
  ,
  parameter int unsigned TRIP_LIMIT   = 480
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [ZONES*TEMP_W-1:0] target_temp,
  input  logic [ZONES*2-1:0]      heat,
  output logic [ZONES*TEMP_W-1:0] current_temp,
  output logic [ZONES-1:0]        preheated,
  output logic                    all_preheated,
  output logic                    tick,
  output logic [ZONES-1:0]        fault
);

  localparam int unsigned     CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            all_q, all_d;

  // tick is registered off the wrap, so zones update on the cycle tick is visible.
  always_comb begin
    tick_d = (cnt_q == CntLast);
    cnt_d  = tick_d ? '0 : cnt_q + CntW'(1);
    all_d  = &preheated;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      all_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      all_q  <= all_d;
    end
  end

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    oven_zone #(
      .TEMP_W      (TEMP_W),
      .AMBIENT     (AMBIENT),
      .TEMP_MAX    (TEMP_MAX),
      .TOL         (TOL),
      .SETTLE_TICKS(SETTLE_TICKS),
      .COOL_RATE   (COOL_RATE)
`ifdef OVERTEMP_TRIP_EN
      ,
      .TRIP_LIMIT  (TRIP_LIMIT)
`endif
    ) u_zone (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .tick_i     (tick_q),
      .enable_i   (enable),
      .target_i   (target_temp[z*TEMP_W +: TEMP_W]),
      .heat_i     (heat[z*2 +: 2]),
      .temp_o     (current_temp[z*TEMP_W +: TEMP_W]),
      .preheated_o(preheated[z]),
      .fault_o    (fault[z])
    );
  end

  assign tick          = tick_q;
  assign all_preheated = all_q;

endmodule

// File: tb/tb_oven_zone_thermal.sv
// Directed-plus-random bench for oven_zone_thermal against a behavioural zone model.
module tb_oven_zone_thermal;
  import oven_pkg::*;

  localparam int Zones   = 2;
  localparam int TempW   = 10;
  localparam int TickDiv = 4;
  localparam int Settle  = 4;
  localparam int Ambient = 65;
  localparam int TempMax = 511;
  localparam int Tol     = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    enable;
  logic [TempW-1:0]        tgt [Zones];
  heat_t                   ht  [Zones];
  logic [Zones*TempW-1:0]  target_temp;
  logic [Zones*TempW-1:0]  current_temp;
  logic [Zones*2-1:0]      heat;
  logic [Zones-1:0]        preheated;
  logic [Zones-1:0]        fault;
  logic                    all_preheated;
  logic                    tick;

  assign target_temp = {tgt[1], tgt[0]};
  assign heat        = {ht[1], ht[0]};

  oven_zone_thermal #(
    .ZONES   (Zones),
    .TICK_DIV(TickDiv)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .target_temp  (target_temp),
    .heat         (heat),
    .current_temp (current_temp),
    .preheated    (preheated),
    .all_preheated(all_preheated),
    .tick         (tick),
    .fault        (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a zone counts consecutive in-band ticks once it has been armed by an enabled tick.
  int m_temp  [Zones];
  bit m_armed [Zones];
  int m_run   [Zones];
  bit m_pre   [Zones];
  bit m_all;
  bit reg_mode [Zones];
  int ecount;
  bit upd_seen;
  int n_cmp;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int reg_heat(input int t, input int target);
    if (t >= target) return 0;
    return (target - t > 3) ? 3 : target - t;
  endfunction

  function automatic bit band(input int t, input int target);
    int lo;
    int hi;
    lo = (target > Tol) ? target - Tol : 0;
    hi = (target + Tol > TempMax) ? TempMax : target + Tol;
    return (target <= TempMax) && (t >= lo) && (t <= hi);
  endfunction

  task automatic model_reset();
    for (int z = 0; z < Zones; z++) begin
      m_temp[z]  = Ambient;
      m_armed[z] = 1'b0;
      m_run[z]   = 0;
      m_pre[z]   = 1'b0;
    end
    m_all = 1'b0;
  endtask

  task automatic model_tick();
    for (int z = 0; z < Zones; z++) begin
      int h;
      h = int'(ht[z]);
      if (enable && h != 0) m_temp[z] = (m_temp[z] + h > TempMax) ? TempMax : m_temp[z] + h;
      else m_temp[z] = (m_temp[z] - 1 < Ambient) ? Ambient : m_temp[z] - 1;
      if (!enable) begin
        m_armed[z] = 1'b0;
        m_run[z]   = 0;
        m_pre[z]   = 1'b0;
      end else if (!m_armed[z]) begin
        m_armed[z] = 1'b1;
        m_run[z]   = 0;
      end else if (band(m_temp[z], int'(tgt[z]))) begin
        if (m_run[z] < 1000) m_run[z]++;
        m_pre[z] = (m_run[z] >= Settle);
      end else begin
        m_run[z] = 0;
        m_pre[z] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check("temp0", 32'(current_temp[TempW-1:0]), 32'(m_temp[0]));
    check("temp1", 32'(current_temp[2*TempW-1:TempW]), 32'(m_temp[1]));
    check("preheated", 32'(preheated), {30'd0, m_pre[1], m_pre[0]});
    check("all_preheated", 32'(all_preheated), 32'(m_all));
    check("fault", 32'(fault), 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    ecount++;
    m_all    = m_pre[0] && m_pre[1];
    upd_seen = 1'b0;
    if (ecount > 1 && ecount % TickDiv == 1) begin
      model_tick();
      upd_seen = 1'b1;
    end
    #1;
    check("tick", 32'(tick), 32'(ecount % TickDiv == 0));
    check_outputs();
  endtask

  task automatic tick_step();
    for (int z = 0; z < Zones; z++) begin
      if (reg_mode[z]) ht[z] = 2'(reg_heat(m_temp[z], int'(tgt[z])));
    end
    upd_seen = 1'b0;
    for (int i = 0; i < 2 * TickDiv && !upd_seen; i++) cycle();
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    ecount   = 0;
    enable   = 1'b0;
    tgt      = '{default: '0};
    ht       = '{default: '0};
    reg_mode = '{default: 1'b0};
    rst_n    = 1'b1;
    model_reset();

    #2 rst_n = 1'b0;
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check_outputs();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    ecount = 0;

    // Heat ramp on zone 0 toward 80, zone 1 regulated to a random target.
    enable      = 1'b1;
    tgt[0]      = 10'd80;
    reg_mode[0] = 1'b1;
    tgt[1]      = 10'($urandom_range(70, 120));
    reg_mode[1] = 1'b1;
    tick_step();
    check("ramp_first_tick", 32'(current_temp[TempW-1:0]), 32'd68);
    repeat (3) tick_step();
    tick_step();
    check("ramp_reach_80", 32'(current_temp[TempW-1:0]), 32'd80);
    tick_step();
    tick_step();
    check("pre_after_3_inband", 32'(preheated[0]), 32'd0);
    tick_step();
    check("pre_after_4_inband", 32'(preheated[0]), 32'd1);

    for (int i = 0; i < 100 && !(m_pre[0] && m_pre[1]); i++) tick_step();
    cycle();
    check("all_rise", 32'(all_preheated), 32'd1);

    // Ready zone loses band on target jump, then a dwell is broken at count 3.
    tgt[0] = 10'd150;
    tick_step();
    check("ready_break", 32'(preheated[0]), 32'd0);
    for (int i = 0; i < 100 && m_run[0] != 3; i++) tick_step();
    check("settle3_not_ready", 32'(preheated[0]), 32'd0);
    tgt[0] = 10'd80;
    tick_step();
    check("dwell_break", 32'(preheated[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick_step();
      check("dwell_break_hold", 32'(preheated[0]), 32'd0);
    end

    // Saturation on zone 1 with an unreachable target; zone 0 settles at 70.
    tgt[1]      = 10'd600;
    reg_mode[1] = 1'b0;
    ht[1]       = 2'd3;
    tgt[0]      = 10'd70;
    for (int i = 0; i < 160; i++) tick_step();
    check("sat_temp", 32'(current_temp[2*TempW-1:TempW]), 32'd511);
    check("sat_no_pre", 32'(preheated[1]), 32'd0);
    for (int i = 0; i < 100 && !(m_temp[0] == 70 && m_pre[0]); i++) tick_step();
    check("cool_start_temp", 32'(current_temp[TempW-1:0]), 32'd70);

    // Cool-down with the oven off.
    enable = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick_step();
      check("cool_temp", 32'(current_temp[TempW-1:0]), 32'(70 - k));
      if (k == 1) check("cool_pre_drop", 32'(preheated[0]), 32'd0);
    end
    repeat (2) tick_step();
    check("cool_floor", 32'(current_temp[TempW-1:0]), 32'd65);

    // Reset mid-run at 200.
    enable      = 1'b1;
    tgt[0]      = 10'd200;
    reg_mode[1] = 1'b1;
    tgt[1]      = 10'($urandom_range(150, 300));
    for (int i = 0; i < 100 && m_temp[0] != 200; i++) tick_step();
    check("pre_reset_temp", 32'(current_temp[TempW-1:0]), 32'd200);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_temp0", 32'(current_temp[TempW-1:0]), 32'd65);
    check("rst_mid_tick", 32'(tick), 32'd0);
    check_outputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    ecount = 0;

    // Random phase.
    for (int i = 0; i < 80; i++) begin
      enable = ($urandom_range(0, 6) != 0);
      for (int z = 0; z < Zones; z++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 9) == 0) tgt[z] = 10'($urandom_range(512, 1023));
          else tgt[z] = 10'($urandom_range(66, 200));
        end
        reg_mode[z] = ($urandom_range(0, 2) != 0);
        if (!reg_mode[z]) ht[z] = 2'($urandom_range(0, 3));
      end
      tick_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
